ram8_fifo: RTL and testbench



---
 rtl/ram8_fifo.sv | 105 ++++++++++
 tb/tb_ram8_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_fifo.sv
// rtl/ram8_fifo.sv - 9-word valid/ready FIFO using a RAM8 as storage behind a registered output slot
module ram8_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        ram_load,
    output logic [2:0]  ram_address,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out
);

    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] ram_cnt;
    logic       pri;

    logic       slot_free;
    logic       bypass;
    logic       rd_req;
    logic       wr_req;
    logic       rd_gnt;
    logic       wr_gnt;
    logic       contended;
    logic [3:0] ram_cnt_nxt;
    logic       out_valid_nxt;

    assign ram_in = in_data;

    // Request generation, single-port arbitration and RAM port drive
    always_comb begin
        slot_free   = !out_valid || out_ready;
        bypass      = (ram_cnt == 4'd0) && slot_free;
        rd_req      = (ram_cnt != 4'd0) && slot_free;
        wr_req      = in_valid && (ram_cnt < 4'd8) && !bypass;
        contended   = rd_req && wr_req;
        rd_gnt      = rd_req && (!wr_req || !pri);
        wr_gnt      = wr_req && (!rd_req || pri);
        in_ready    = bypass ? 1'b1 : ((ram_cnt < 4'd8) && !rd_gnt);
        ram_address = wr_gnt ? wr_ptr : rd_ptr;
        ram_load    = wr_gnt && rst_n;
    end

    // Next occupancy of the RAM and the output slot, used for the registered count
    always_comb begin
        ram_cnt_nxt = ram_cnt;
        if (wr_gnt) begin
            ram_cnt_nxt = ram_cnt + 4'd1;
        end else if (rd_gnt) begin
            ram_cnt_nxt = ram_cnt - 4'd1;
        end
        out_valid_nxt = out_valid;
        if (bypass && in_valid) begin
            out_valid_nxt = 1'b1;
        end else if (rd_gnt) begin
            out_valid_nxt = 1'b1;
        end else if (out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // Pointers, RAM occupancy, arbitration priority and registered count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 3'd0;
            rd_ptr  <= 3'd0;
            ram_cnt <= 4'd0;
            pri     <= 1'b0;
            count   <= 4'd0;
        end else begin
            if (wr_gnt) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (rd_gnt) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            if (contended) begin
                pri <= !pri;
            end
            ram_cnt <= ram_cnt_nxt;
            count   <= ram_cnt_nxt + {3'd0, out_valid_nxt};
        end
    end

    // Output slot: bypass load from the producer, refill from RAM, or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            out_valid <= out_valid_nxt;
            if (bypass && in_valid) begin
                out_data <= in_data;
            end else if (rd_gnt) begin
                out_data <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram8_fifo.sv
// tb/tb_ram8_fifo.sv - directed self-checking bench for ram8_fifo with a RAM8 model and scoreboard
module tb_ram8_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        ram_load;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic [15:0] ram_out;

    logic [15:0] mem [8];
    logic [15:0] sb [$];
    int          errors;
    int          checks;

    ram8_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM8 model: combinational read, write on rising edge when load is high
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: score handshakes before the edge, then compare count after it
    task automatic tick();
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_on_empty", 32'd1, 32'd0);
            end else begin
                check("pop_data", {16'd0, out_data}, {16'd0, sb[0]});
                void'(sb.pop_front());
            end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge clk);
        #1;
        check("count", {28'd0, count}, sb.size());
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ram_load", {31'd0, ram_load}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass: consumer always ready, one word per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            #1;
            check("byp_in_ready", {31'd0, in_ready}, 32'd1);
            check("byp_ram_load", {31'd0, ram_load}, 32'd0);
            tick();
            check("byp_out_valid", {31'd0, out_valid}, 32'd1);
            check("byp_out_data", {16'd0, out_data}, i);
        end
        in_valid = 1'b0;
        #1;
        tick();
        check("byp_drained", {31'd0, out_valid}, 32'd0);

        // Fill: stalled consumer, 10 pushes, only 9 fit
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(i);
            #1;
            if (i == 0) begin
                check("fill_bypass_load", {31'd0, ram_load}, 32'd0);
                check("fill_in_ready0", {31'd0, in_ready}, 32'd1);
            end else if (i < 9) begin
                check("fill_in_ready", {31'd0, in_ready}, 32'd1);
                check("fill_ram_load", {31'd0, ram_load}, 32'd1);
                check("fill_ram_addr", {29'd0, ram_address}, i - 1);
            end else begin
                check("full_in_ready", {31'd0, in_ready}, 32'd0);
                check("full_ram_load", {31'd0, ram_load}, 32'd0);
            end
            tick();
        end
        check("full_count", {28'd0, count}, 32'd9);

        // Drain: words 1000..1008 in order, then empty
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            #1;
            check("drain_valid", {31'd0, out_valid}, 32'd1);
            check("drain_data", {16'd0, out_data}, 32'h1000 + j);
            tick();
        end
        check("drain_empty_valid", {31'd0, out_valid}, 32'd0);
        check("drain_empty_count", {28'd0, count}, 32'd0);

        // Wrap: pointers back at 0, next RAM writes land at 0..3
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h2000 + 16'(i);
            #1;
            if (i > 0) begin
                check("wrap_ram_load", {31'd0, ram_load}, 32'd1);
                check("wrap_ram_addr", {29'd0, ram_address}, i - 1);
            end
            tick();
        end
        check("wrap_count", {28'd0, count}, 32'd5);
        check("wrap_mem0", {16'd0, mem[0]}, 32'h2001);
        check("wrap_mem3", {16'd0, mem[3]}, 32'h2004);

        // Contention: push and pop demand together, grants alternate read first
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h3000 + 16'(c);
            #1;
            check("cont_ram_load", {31'd0, ram_load}, c % 2);
            check("cont_in_ready", {31'd0, in_ready}, c % 2);
            tick();
        end

        // Refill to full with a stalled consumer
        out_ready = 1'b0;
        for (int k = 0; k < 30 && count != 4'd9; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h4000 + 16'(k);
            #1;
            tick();
        end
        check("refill_count", {28'd0, count}, 32'd9);

        // Full plus simultaneous pop: read wins, push rejected that cycle
        in_valid  = 1'b1;
        in_data   = 16'h5000;
        out_ready = 1'b1;
        #1;
        check("fullpop_in_ready", {31'd0, in_ready}, 32'd0);
        check("fullpop_ram_load", {31'd0, ram_load}, 32'd0);
        tick();
        check("fullpop_count", {28'd0, count}, 32'd8);
        out_ready = 1'b0;
        in_data   = 16'h5001;
        #1;
        check("fullpop_next_ready", {31'd0, in_ready}, 32'd1);
        check("fullpop_next_load", {31'd0, ram_load}, 32'd1);
        tick();
        check("fullpop_next_count", {28'd0, count}, 32'd9);

        // Drain to 5 words, then reset mid-stream
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            tick();
        end
        check("pre_rst_count", {28'd0, count}, 32'd5);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h6000;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_load", {31'd0, ram_load}, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        #1;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_data", {16'd0, out_data}, 32'hA5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
